uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter DBIT, default 8, SHALL set the number of data bits per frame; legal range 5..8.
REQ-002 Parameter SBTICK, default 16, SHALL set the stop-bit length in s_tick units: 16 = 1 stop bit, 24 = 1.5, 32 = 2.
REQ-003 Parameter PARITY, default 0, SHALL select the parity mode: 0 none, 1 even, 2 odd.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 s_tick  input  1  SHALL be a one-cycle enable at 16x the baud rate.
REQ-007 tx_start  input  1  SHALL be a one-cycle request to load din.
REQ-008 din  input  8  SHALL carry the byte to send; bits above DBIT-1 are ignored.
REQ-009 tx_ready  output  1  SHALL be high when the holding register is empty and can accept tx_start.
REQ-010 tx_busy  output  1  SHALL be high whenever the FSM is not in idle.
REQ-011 tx_done_tick  output  1  SHALL be a one-cycle pulse at the end of each frame's stop period.
REQ-012 tx  output  1  SHALL be the serial line, idle high.

Function
REQ-013 A one-entry holding register plus valid flag SHALL buffer one byte; tx_ready = !valid.
REQ-014 tx_start with tx_ready=1 SHALL capture din and set valid at that clk edge.
REQ-015 tx_start with tx_ready=0 SHALL be ignored: no overwrite and no error state.
REQ-016 FSM states SHALL be idle, start, data, parity, stop.
REQ-017 In idle with valid=1, the next edge SHALL: enter start, move the held byte into the shift register, clear valid, and zero the tick counter s and the bit counter n.
REQ-018 A tx_start in the same cycle as the transfer of REQ-017 SHALL be accepted, leaving valid=1.
REQ-019 tx SHALL be registered so it has no glitches: 1 in idle, 0 in start, shift[0] in data, the parity bit in parity, 1 in stop.
REQ-020 Each of start, data and parity SHALL last exactly 16 s_ticks; s advances only on s_tick and wraps to 0 at 15 on the state or bit change.
REQ-021 Data bits SHALL be sent LSB first; at s=15 the register shifts right and n increments.
REQ-022 After bit n=DBIT-1, the FSM SHALL enter parity if PARITY != 0, otherwise stop.
REQ-023 Parity SHALL be computed from the DBIT data bits: even = XOR of the bits, odd = its inverse.
REQ-024 Stop SHALL last SBTICK s_ticks; at s=SBTICK-1 on s_tick, tx_done_tick=1 for that cycle.
REQ-025 On that same edge, the FSM SHALL enter idle.
REQ-026 If valid=1 at frame end, start SHALL follow with exactly one idle cycle between frames.
REQ-027 With s_tick continuously low, the FSM, counters and tx SHALL hold.
REQ-028 Total frame length SHALL be 16*(1+DBIT+(PARITY!=0)) + SBTICK s_ticks.

Reset
REQ-029 reset_n=0 SHALL immediately force: state=idle, s=0, n=0, shift=0, hold=0, valid=0, tx=1, tx_done_tick=0, tx_busy=0, tx_ready=1.
REQ-030 Reset mid-frame SHALL abort the frame with no done pulse; a queued byte is lost.
REQ-031 Normal operation SHALL resume on the first clk edge after reset_n rises.

Structure
REQ-032 The state encoding and the PARITY mode constants SHALL live in a shared uart package used by both UART directions.
REQ-033 The block SHALL be a single module with no sub-modules; the s_tick generator is external.

Verification
REQ-034 8N1 (DBIT=8, PARITY=0, SBTICK=16), s_tick every 4 clk, send 0x55 -> tx reads 0,1,0,1,0,1,0,1,0,1, each level 64 clk; tx_done_tick fires once, 640 clk after start.
REQ-035 PARITY=1, send 0x07 -> parity bit 1; PARITY=2, send 0x07 -> parity bit 0; frames are 176 s_ticks.
REQ-036 Send 0xA3, then 0x3C while busy -> tx_ready=0 after the second load; a third tx_start is ignored; 0x3C follows 0xA3 after one idle cycle.
REQ-037 Assert reset_n=0 during data bit 3 of 0xFF -> tx=1 and tx_busy=0 immediately; no tx_done_tick; the next frame is correct.
REQ-038 DBIT=7, SBTICK=32, send 0x81 -> 7 data bits 1,0,0,0,0,0,0, then tx high for 32 s_ticks.
REQ-039 Hold s_tick=0 for 100 clk mid-bit -> tx and state unchanged; timing resumes exactly.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity helper.
// Imported by both the transmitter and the receiver side.
package uart_transmitter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityEven = 1;
  localparam int unsigned ParityOdd  = 2;

  localparam logic [4:0] TickLast = 5'd15;

  // Parity over the low dbit bits; odd mode inverts the even result.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned dbit,
                                      input int unsigned mode);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < dbit) p ^= data[i];
    end
    return (mode == ParityOdd) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side handshake of the UART transmitter: load request, data and status.
interface uart_transmitter_if;
  logic       tx_start;
  logic [7:0] din;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done_tick;

  modport master (output tx_start, din, input tx_ready, tx_busy, tx_done_tick);
  modport slave  (input tx_start, din, output tx_ready, tx_busy, tx_done_tick);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter with a one-entry holding register, optional parity and
// configurable stop length, paced by an external 16x-baud s_tick enable.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned SBTICK = 16,
  parameter int unsigned PARITY = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_tick,
  uart_transmitter_if.slave   host,
  output logic                tx
);

  localparam logic [2:0] NLast    = 3'(DBIT - 1);
  localparam logic [4:0] StopLast = 5'(SBTICK - 1);
  localparam logic [7:0] DataMask = 8'((32'd1 << DBIT) - 32'd1);

  uart_state_e state_q, state_d;
  logic [4:0]  s_q, s_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        valid_q, valid_d;
  logic        tx_q, tx_d;
  logic        par_q, par_d;
  logic        xfer;
  logic        done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      tx_q    <= 1'b1;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      tx_q    <= tx_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    par_d   = par_q;
    xfer    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (valid_q) begin
          xfer    = 1'b1;
          state_d = StStart;
          shift_d = hold_q;
          par_d   = parity_bit(hold_q, DBIT, PARITY);
          s_d     = '0;
          n_d     = '0;
          valid_d = 1'b0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == TickLast) begin
            s_d     = '0;
            state_d = StData;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == TickLast) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == NLast) begin
              state_d = (PARITY != ParityNone) ? StParity : StStop;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StParity: begin
        if (s_tick) begin
          if (s_q == TickLast) begin
            s_d     = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == StopLast) begin
            s_d     = '0;
            state_d = StIdle;
            done    = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A load in the same cycle as the hand-off to the shifter refills the slot.
    if (host.tx_start && (!valid_q || xfer)) begin
      hold_d  = host.din & DataMask;
      valid_d = 1'b1;
    end

    // Line level is computed from the next state so tx itself is a flop output.
    case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign host.tx_ready     = ~valid_q;
  assign host.tx_busy      = (state_q != StIdle);
  assign host.tx_done_tick = done;
  assign tx                = tx_q;

endmodule
